// File: rtl/mac_lookup_arbiter_if.sv
// Request, lookup, result and per-requester delivery channels of the MAC lookup arbiter.
// NUM_REQ must match the NUM_REQ of the arbiter that uses this bundle.
interface mac_lookup_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]     req_tvalid;
  logic [NUM_REQ-1:0]     req_tready;
  logic [NUM_REQ*114-1:0] req_tdata;
  logic [NUM_REQ*5-1:0]   req_tid;

  logic                   lookup_tvalid;
  logic                   lookup_tready;
  logic [113:0]           lookup_tdata;
  logic [4:0]             lookup_tid;
  logic [1:0]             lookup_tdest;

  logic                   res_tvalid;
  logic                   res_tready;
  logic [5:0]             res_tdata;
  logic [4:0]             res_tid;
  logic [1:0]             res_tdest;
  logic                   res_tuser;

  logic [NUM_REQ-1:0]     out_tvalid;
  logic [NUM_REQ-1:0]     out_tready;
  logic [NUM_REQ*6-1:0]   out_tdata;
  logic [NUM_REQ*5-1:0]   out_tid;
  logic [NUM_REQ-1:0]     out_tuser;

  logic                   err_bad_dest;
  logic                   err_underflow;

  modport slave (
    input  req_tvalid, req_tdata, req_tid, lookup_tready,
           res_tvalid, res_tdata, res_tid, res_tdest, res_tuser, out_tready,
    output req_tready, lookup_tvalid, lookup_tdata, lookup_tid, lookup_tdest,
           res_tready, out_tvalid, out_tdata, out_tid, out_tuser,
           err_bad_dest, err_underflow
  );

  modport master (
    output req_tvalid, req_tdata, req_tid, lookup_tready,
           res_tvalid, res_tdata, res_tid, res_tdest, res_tuser, out_tready,
    input  req_tready, lookup_tvalid, lookup_tdata, lookup_tid, lookup_tdest,
           res_tready, out_tvalid, out_tdata, out_tid, out_tuser,
           err_bad_dest, err_underflow
  );
endinterface

// File: rtl/mac_lookup_arbiter.sv
// Round-robin arbiter sharing one MAC-table lookup channel among NUM_REQ requesters,
// with per-requester outstanding-lookup credits and zero-latency result routing.
module mac_lookup_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input logic                 clk_fabric,
  input logic                 rst,
  mac_lookup_arbiter_if.slave bus
);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic          lookup_tvalid_q, lookup_tvalid_d;
  logic [113:0]  lookup_tdata_q, lookup_tdata_d;
  logic [4:0]    lookup_tid_q, lookup_tid_d;
  logic [1:0]    lookup_tdest_q, lookup_tdest_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q [NUM_REQ];
  logic [CW-1:0] cnt_d [NUM_REQ];
  logic          err_bad_dest_q, err_bad_dest_d;
  logic          err_underflow_q, err_underflow_d;

  logic               slot_free;
  logic               grant_vld;
  logic [1:0]         grant_idx;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] dec;
  logic               res_bad;
  logic               res_ready;
  logic               res_hs;

  function automatic logic [1:0] wrap_idx(input int i);
    return (i >= NUM_REQ) ? 2'(i - NUM_REQ) : 2'(i);
  endfunction

  always_comb begin
    slot_free = !lookup_tvalid_q || bus.lookup_tready;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_tvalid[i] && (cnt_q[i] < CNT_MAX);
    end
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    // Walk backwards so the eligible requester nearest the pointer is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[wrap_idx(int'(ptr_q) + k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_idx(int'(ptr_q) + k);
      end
    end
    grant_vld = grant_vld && slot_free && !rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant_vld && (grant_idx == 2'(i));
    end
  end

  // Result routing: unknown destinations are swallowed so the shared path never wedges.
  always_comb begin
    res_bad   = (int'(bus.res_tdest) >= NUM_REQ);
    res_ready = res_bad;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.res_tdest == 2'(i)) res_ready = bus.out_tready[i];
    end
    res_hs = bus.res_tvalid && res_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec[i] = res_hs && (bus.res_tdest == 2'(i));
    end
  end

  always_comb begin
    lookup_tvalid_d = lookup_tvalid_q;
    lookup_tdata_d  = lookup_tdata_q;
    lookup_tid_d    = lookup_tid_q;
    lookup_tdest_d  = lookup_tdest_q;
    ptr_d           = ptr_q;
    err_bad_dest_d  = res_hs && res_bad;
    err_underflow_d = 1'b0;
    if (slot_free) begin
      lookup_tvalid_d = grant_vld;
      if (grant_vld) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_oh[i]) begin
            lookup_tdata_d = bus.req_tdata[i*114 +: 114];
            lookup_tid_d   = bus.req_tid[i*5 +: 5];
          end
        end
        lookup_tdest_d = grant_idx;
        ptr_d          = wrap_idx(int'(grant_idx) + 1);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_oh[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec[i] && !grant_oh[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (dec[i] && (cnt_q[i] == '0)) err_underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      lookup_tvalid_q <= 1'b0;
      lookup_tdata_q  <= '0;
      lookup_tid_q    <= '0;
      lookup_tdest_q  <= '0;
      ptr_q           <= '0;
      err_bad_dest_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      lookup_tvalid_q <= lookup_tvalid_d;
      lookup_tdata_q  <= lookup_tdata_d;
      lookup_tid_q    <= lookup_tid_d;
      lookup_tdest_q  <= lookup_tdest_d;
      ptr_q           <= ptr_d;
      err_bad_dest_q  <= err_bad_dest_d;
      err_underflow_q <= err_underflow_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.req_tready    = grant_oh;
  assign bus.lookup_tvalid = lookup_tvalid_q;
  assign bus.lookup_tdata  = lookup_tdata_q;
  assign bus.lookup_tid    = lookup_tid_q;
  assign bus.lookup_tdest  = lookup_tdest_q;
  assign bus.res_tready    = res_ready;
  assign bus.out_tdata     = {NUM_REQ{bus.res_tdata}};
  assign bus.out_tid       = {NUM_REQ{bus.res_tid}};
  assign bus.out_tuser     = {NUM_REQ{bus.res_tuser}};
  assign bus.err_bad_dest  = err_bad_dest_q;
  assign bus.err_underflow = err_underflow_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.out_tvalid[i] = bus.res_tvalid && (bus.res_tdest == 2'(i));
    end
  end
endmodule
